// File: rtl/elevador_pkg.sv
// Shared constants and helpers for the elevator call latch.
// Floor count, index width, default debounce length, direction codes.
package elevador_pkg;

    localparam int N_FLOORS       = 4;
    localparam int FLOOR_W        = 2;
    localparam int DEB_CYCLES_DEF = 500000;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef struct packed {
        logic   found;
        floor_t floor;
    } pick_t;

    // Nearest pending floor strictly above (up=1) or below (up=0) cur.
    function automatic pick_t nearest(
        input logic [N_FLOORS-1:0] calls,
        input floor_t              cur,
        input logic                up
    );
        pick_t r;
        r = '0;
        if (up == UP) begin
            for (int i = N_FLOORS - 1; i >= 0; i--) begin
                if (calls[i] && (i > int'(cur))) begin
                    r.found = 1'b1;
                    r.floor = floor_t'(i);
                end
            end
        end else begin
            for (int i = 0; i < N_FLOORS; i++) begin
                if (calls[i] && (i < int'(cur))) begin
                    r.found = 1'b1;
                    r.floor = floor_t'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/elevador_debounce.sv
// One call key: 2-flop synchronizer, debounce counter, press pulse.
// Counter is built only when ELEVADOR_DEBOUNCE_EN is defined.
module elevador_debounce
    import elevador_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic s1;
    logic s2;
    logic down;
    logic down_q;

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("DEB_CYCLES must be at least 1");
    end

    // Bring the asynchronous active-low key into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

`ifdef ELEVADOR_DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Accept a level change only after it has been stable long enough.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            down <= 1'b0;
        end else if (~s2 == down) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            down <= ~down;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign down = ~s2;
`endif

    // Remember the previous stable level for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            down_q <= 1'b0;
        end else begin
            down_q <= down;
        end
    end

    assign press = down & ~down_q;

endmodule

// File: rtl/elevador_chamadas.sv
// Elevator call latch: debounced keys set pending calls, next target chosen.
// Build option ELEVADOR_DEBOUNCE_EN enables the per-key debounce counter.
module elevador_chamadas
    import elevador_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int N_FLOORS   = elevador_pkg::N_FLOORS
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] key_n,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                dir_up,
    input  logic                door_open,
    input  logic                emerg,
    output logic [N_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]  target_floor,
    output logic                target_valid
);

    logic [N_FLOORS-1:0] press;
    logic [N_FLOORS-1:0] clr;
    logic [N_FLOORS-1:0] pend_nxt;
    floor_t              tgt_nxt;
    logic                tgt_valid_nxt;
    pick_t               ahead;
    pick_t               behind;

    if (N_FLOORS != 4) begin : g_bad_floors
        $error("Only 4 floors are supported");
    end

    for (genvar g = 0; g < N_FLOORS; g++) begin : g_key
        elevador_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clock (clock),
            .reset (reset),
            .key_n (key_n[g]),
            .press (press[g])
        );
    end

    // Set on press, clear on door open at that floor; clear dominates.
    always_comb begin
        clr = '0;
        if (door_open) begin
            clr[cur_floor] = 1'b1;
        end
        if (emerg) begin
            pend_nxt = '0;
        end else begin
            pend_nxt = (pending | press) & ~clr;
        end
    end

    // Pending call register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

    // Choose here, then nearest ahead, then nearest behind.
    always_comb begin
        ahead         = nearest(pending, cur_floor, dir_up);
        behind        = nearest(pending, cur_floor, ~dir_up);
        tgt_nxt       = target_floor;
        tgt_valid_nxt = 1'b0;
        if (emerg) begin
            tgt_valid_nxt = 1'b0;
        end else if (pending[cur_floor] && !door_open) begin
            tgt_nxt       = cur_floor;
            tgt_valid_nxt = 1'b1;
        end else if (ahead.found) begin
            tgt_nxt       = ahead.floor;
            tgt_valid_nxt = 1'b1;
        end else if (behind.found) begin
            tgt_nxt       = behind.floor;
            tgt_valid_nxt = 1'b1;
        end
    end

    // Registered target; floor holds while nothing is pending.
    always_ff @(posedge clock) begin
        if (reset) begin
            target_floor <= '0;
            target_valid <= 1'b0;
        end else begin
            target_floor <= tgt_nxt;
            target_valid <= tgt_valid_nxt;
        end
    end

endmodule

// File: tb/tb_elevador_chamadas.sv
// Self-checking bench for elevador_chamadas.
// Expected press latency follows ELEVADOR_DEBOUNCE_EN.
module tb_elevador_chamadas;

    localparam int DEB = 4;
`ifdef ELEVADOR_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
    localparam logic [3:0] GLITCH_EXP = 4'b0000;
`else
    localparam int LAT = 3;
    localparam logic [3:0] GLITCH_EXP = 4'b0010;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] key_n;
    logic [1:0] cur_floor;
    logic       dir_up;
    logic       door_open;
    logic       emerg;
    logic [3:0] pending;
    logic [1:0] target_floor;
    logic       target_valid;

    int n_tests = 0;
    int n_fail  = 0;

    elevador_chamadas #(
        .DEB_CYCLES (DEB),
        .N_FLOORS   (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .key_n        (key_n),
        .cur_floor    (cur_floor),
        .dir_up       (dir_up),
        .door_open    (door_open),
        .emerg        (emerg),
        .pending      (pending),
        .target_floor (target_floor),
        .target_valid (target_valid)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [3:0] pend;
        logic [1:0] tf;
        logic       tv;
        logic [2:0] chk;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] cur;
        logic       dir;
        logic       door;
        logic [3:0] pend;
        logic [1:0] tf;
        logic       tv;
    } vec_t;

    exp_t sb[$];
    vec_t vt[12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(string name, logic [3:0] p, logic [1:0] f,
                              logic v, logic [2:0] chk);
        exp_t e;
        e.name = name;
        e.pend = p;
        e.tf   = f;
        e.tv   = v;
        e.chk  = chk;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: no expectation queued");
            return;
        end
        e = sb.pop_front();
        if (e.chk[2]) begin
            n_tests++;
            if (pending !== e.pend) begin
                n_fail++;
                $display("FAIL %s pending: got %b want %b",
                         e.name, pending, e.pend);
            end
        end
        if (e.chk[1]) begin
            n_tests++;
            if (target_floor !== e.tf) begin
                n_fail++;
                $display("FAIL %s target_floor: got %0d want %0d",
                         e.name, target_floor, e.tf);
            end
        end
        if (e.chk[0]) begin
            n_tests++;
            if (target_valid !== e.tv) begin
                n_fail++;
                $display("FAIL %s target_valid: got %b want %b",
                         e.name, target_valid, e.tv);
            end
        end
    endtask

    task automatic chk(string name, logic [3:0] p, logic [1:0] f,
                       logic v, logic [2:0] m);
        expect_out(name, p, f, v, m);
        check_out();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        key_n     = 4'hF;
        cur_floor = 2'd0;
        dir_up    = 1'b1;
        door_open = 1'b0;
        emerg     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load(logic [3:0] mask);
        key_n = ~mask;
        repeat (LAT) tick();
        key_n = 4'hF;
        repeat (LAT + 3) tick();
    endtask

    initial begin
        vt[0]  = '{4'b1001, 2'd1, 1'b1, 1'b0, 4'b1001, 2'd3, 1'b1};
        vt[1]  = '{4'b1001, 2'd1, 1'b0, 1'b0, 4'b1001, 2'd0, 1'b1};
        vt[2]  = '{4'b0110, 2'd2, 1'b1, 1'b0, 4'b0110, 2'd2, 1'b1};
        vt[3]  = '{4'b0110, 2'd2, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1};
        vt[4]  = '{4'b0101, 2'd1, 1'b1, 1'b0, 4'b0101, 2'd2, 1'b1};
        vt[5]  = '{4'b0101, 2'd1, 1'b0, 1'b0, 4'b0101, 2'd0, 1'b1};
        vt[6]  = '{4'b1000, 2'd0, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1};
        vt[7]  = '{4'b0001, 2'd3, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1};
        vt[8]  = '{4'b0000, 2'd2, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0};
        vt[9]  = '{4'b1100, 2'd0, 1'b1, 1'b0, 4'b1100, 2'd2, 1'b1};
        vt[10] = '{4'b0011, 2'd3, 1'b0, 1'b0, 4'b0011, 2'd1, 1'b1};
        vt[11] = '{4'b0001, 2'd0, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0};

        // Reset state
        do_reset();
        chk("reset", 4'b0000, 2'd0, 1'b0, 3'b111);

        // Press latency and target follow-up on floor 2
        key_n = 4'b1011;
        repeat (LAT - 1) tick();
        chk("lat_before", 4'b0000, 2'd0, 1'b0, 3'b100);
        tick();
        chk("lat_set", 4'b0100, 2'd0, 1'b0, 3'b111);
        tick();
        chk("lat_target", 4'b0100, 2'd2, 1'b1, 3'b111);
        repeat (LAT + 2) tick();
        chk("hold_one_event", 4'b0100, 2'd2, 1'b1, 3'b100);
        key_n = 4'hF;

        // Short glitch on key 1
        do_reset();
        key_n = 4'b1101;
        repeat (3) tick();
        key_n = 4'hF;
        repeat (10) tick();
        chk("glitch", GLITCH_EXP, 2'd0, 1'b0, 3'b100);

        // Target selection table
        for (int i = 0; i < 12; i++) begin
            do_reset();
            load(vt[i].mask);
            cur_floor = vt[i].cur;
            dir_up    = vt[i].dir;
            door_open = vt[i].door;
            tick();
            tick();
            chk($sformatf("vec%0d", i), vt[i].pend, vt[i].tf, vt[i].tv,
                3'b111);
        end

        // Clear wins over a simultaneous press at the open floor
        do_reset();
        load(4'b0010);
        cur_floor = 2'd1;
        key_n     = 4'b1101;
        repeat (LAT - 1) tick();
        chk("clr_pre", 4'b0010, 2'd0, 1'b0, 3'b100);
        door_open = 1'b1;
        tick();
        chk("clr_wins", 4'b0000, 2'd0, 1'b0, 3'b100);
        door_open = 1'b0;
        repeat (3) tick();
        chk("clr_no_repress", 4'b0000, 2'd0, 1'b0, 3'b100);
        key_n = 4'hF;

        // Emergency flush and discarded presses
        do_reset();
        load(4'b1110);
        chk("emerg_pre", 4'b1110, 2'd1, 1'b1, 3'b111);
        emerg = 1'b1;
        tick();
        chk("emerg_flush", 4'b0000, 2'd0, 1'b0, 3'b101);
        key_n = 4'b1110;
        repeat (LAT + 2) tick();
        chk("emerg_hold", 4'b0000, 2'd0, 1'b0, 3'b101);
        emerg = 1'b0;
        repeat (4) tick();
        chk("emerg_after", 4'b0000, 2'd0, 1'b0, 3'b101);
        key_n = 4'hF;

        // Reset in the middle of a press restarts the full period
        do_reset();
        key_n = 4'b0111;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_clear", 4'b0000, 2'd0, 1'b0, 3'b111);
        repeat (LAT - 1) tick();
        chk("midrst_before", 4'b0000, 2'd0, 1'b0, 3'b100);
        tick();
        chk("midrst_set", 4'b1000, 2'd0, 1'b0, 3'b100);
        key_n = 4'hF;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/elevador_chamadas.md
ELEVADOR_CHAMADAS -- requirements
Module: elevador_chamadas

Interface
REQ-001 Parameter: DEB_CYCLES, 500000, number of consecutive stable samples before a key change is accepted (10 ms at 50 MHz).
REQ-002 Parameter: N_FLOORS, 4, number of floors served (fixed at 4 in this revision).
REQ-003 clock  input  1  system clock, single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_n  input  4  raw call buttons, active-low, asynchronous; bit i requests floor i.
REQ-006 cur_floor  input  2  current floor reported by the controller, valid every cycle.
REQ-007 dir_up  input  1  controller travel direction: 1 = up, 0 = down.
REQ-008 door_open  input  1  controller door-open indication.
REQ-009 emerg  input  1  emergency switch, active-high, synchronous to clock.
REQ-010 pending  output  4  latched outstanding calls, one bit per floor; also drives the call LEDs.
REQ-011 target_floor  output  2  next floor the controller shall serve.
REQ-012 target_valid  output  1  high when target_floor is meaningful.

Function
REQ-013 Each key_n bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each synchronized key SHALL be debounced by its own counter: it counts while the synchronized value differs from the stable state, resets to 0 when they match, and the stable state toggles when the count reaches DEB_CYCLES-1.
REQ-015 A press event SHALL be a one-cycle pulse on the stable-state transition released->pressed; release SHALL generate no event.
REQ-016 A press event SHALL set pending[i] on the next edge; holding key_n low SHALL produce exactly one press event.
REQ-017 pending[i] SHALL clear on the edge where door_open=1 and cur_floor=i.
REQ-018 If set and clear of the same bit coincide, clear SHALL win.
REQ-019 Target selection priority SHALL be, in order: pending[cur_floor] with door_open=0; nearest pending floor strictly ahead in dir_up direction; nearest pending floor strictly behind.
REQ-020 target_floor and target_valid SHALL be registered, updating one edge after pending or its inputs change.
REQ-021 With no pending bit set, target_valid SHALL be 0 and target_floor SHALL hold its last value.
REQ-022 While emerg=1, pending SHALL be forced to 0, press events SHALL be discarded, and target_valid SHALL be 0; debounce state keeps running.
REQ-023 Presses completing debounce while emerg=1 SHALL NOT be latched after emerg falls.

Reset
REQ-024 On reset: pending=0, target_floor=0, target_valid=0, all debounce counters=0, all stable states=released, synchronizer flops=1.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; a key still held after reset SHALL register after a full debounce period.

Configuration
REQ-026 Macro ELEVADOR_DEBOUNCE_EN: when defined, debounce per REQ-014; when undefined, the synchronizer output is the stable state directly (DEB_CYCLES ignored), giving press-to-pending latency of 3 edges instead of DEB_CYCLES+3.

Structure
REQ-027 Shared package elevador_pkg SHALL hold N_FLOORS, the floor-index width, the default DEB_CYCLES, and the direction encoding constants (UP=1, DOWN=0).
REQ-028 One sub-module, elevador_debounce (synchronizer plus counter plus press-pulse, one key), SHALL be instantiated once per floor.

Verification (DEB_CYCLES=4, macro defined unless noted)
REQ-029 Reset, then key_n[2] held low -> pending=0100 exactly 7 edges after first low sample; target_floor=2, target_valid=1 one edge later.
REQ-030 key_n[1] glitch low for 3 cycles -> pending stays 0000.
REQ-031 cur_floor=1, dir_up=1, pending=1001 -> target_floor=3; dir_up=0 -> target_floor=0.
REQ-032 pending=0010, cur_floor=1, door_open=1 in the same cycle as a new key_n[1] press event -> pending=0000 (clear wins).
REQ-033 pending=1110, emerg=1 -> pending=0000, target_valid=0 next edge; key_n[0] pressed during emerg, emerg released -> pending stays 0000.
REQ-034 Macro undefined: key_n[3] low -> pending=1000 after 3 edges.
